// File: rtl/alu_share_arbiter.sv
// Shares one 64-bit integer ALU between two requesters. Arbitration is
// round-robin and the result lands in a single registered response stage.

module alu (
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [63:0] rs1,
  input  logic [63:0] rs2,
  output logic [63:0] rd
);
  logic [5:0] shamt;
  assign shamt = rs2[5:0];

  // Any funct3/funct7 pairing not listed below falls back to add.
  always_comb begin
    rd = rs1 + rs2;
    if (funct7 == 7'b0000000) begin
      case (funct3)
        3'b001:  rd = rs1 << shamt;
        3'b010:  rd = {63'd0, $signed(rs1) < $signed(rs2)};
        3'b011:  rd = {63'd0, rs1 < rs2};
        3'b100:  rd = rs1 ^ rs2;
        3'b101:  rd = rs1 >> shamt;
        3'b110:  rd = rs1 | rs2;
        3'b111:  rd = rs1 & rs2;
        default: rd = rs1 + rs2;
      endcase
    end else if (funct7 == 7'b0100000) begin
      if (funct3 == 3'b000)      rd = rs1 - rs2;
      else if (funct3 == 3'b101) rd = $signed(rs1) >>> shamt;
    end
  end
endmodule

module alu_share_arbiter #(
  parameter int RR_INIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_funct3,
  input  logic [6:0]  req0_funct7,
  input  logic [63:0] req0_rs1,
  input  logic [63:0] req0_rs2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_funct3,
  input  logic [6:0]  req1_funct7,
  input  logic [63:0] req1_rs1,
  input  logic [63:0] req1_rs2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_rd
);
  // Handshake: a transfer happens on any cycle where valid && ready are both
  // high at the rising edge. Ready may look at valid; valid never looks at ready.

  localparam logic PTR_INIT = (RR_INIT != 0);

  logic        ptr_q, ptr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [63:0] rsp_rd_q, rsp_rd_d;

  logic        any_valid;
  logic        grant_id;
  logic        slot_free;
  logic        accept;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic [63:0] alu_rs1, alu_rs2, alu_rd;

  assign any_valid = req0_valid || req1_valid;
  // Contention goes to ptr; otherwise the lone requester wins (0 when idle).
  assign grant_id  = (req0_valid && req1_valid) ? ptr_q : req1_valid;
  assign slot_free = !rsp_valid_q || rsp_ready;
  assign accept    = any_valid && slot_free && !reset;

  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;

  always_comb begin
    alu_funct3 = req0_funct3;
    alu_funct7 = req0_funct7;
    alu_rs1    = req0_rs1;
    alu_rs2    = req0_rs2;
    if (grant_id) begin
      alu_funct3 = req1_funct3;
      alu_funct7 = req1_funct7;
      alu_rs1    = req1_rs1;
      alu_rs2    = req1_rs2;
    end
  end

  alu u_alu (
    .funct3 (alu_funct3),
    .funct7 (alu_funct7),
    .rs1    (alu_rs1),
    .rs2    (alu_rs2),
    .rd     (alu_rd)
  );

  // A drain and a new accept in the same cycle simply overwrite the stage.
  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_rd_d    = rsp_rd_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant_id;
      rsp_rd_d    = alu_rd;
      ptr_d       = !grant_id;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= PTR_INIT;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_rd_q    <= 64'd0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rd_q    <= rsp_rd_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_rd    = rsp_rd_q;
endmodule
